// File: rtl/biriscv_v_alu_pipe_pkg.sv
// Shared decode constants, types and lane arithmetic for the vector integer ALU.
package biriscv_v_alu_pipe_pkg;

    // Major opcode / funct3 scalar-operand forms
    localparam logic [6:0] OPC_OP_V     = 7'b1010111;
    localparam logic [2:0] FUNCT3_OPIVV = 3'b000;
    localparam logic [2:0] FUNCT3_OPIVX = 3'b100;
    localparam logic [2:0] FUNCT3_OPIVI = 3'b011;

    // vsew encodings; 2'b11 is reserved and handled as 32-bit
    localparam logic [1:0] VSEW_8  = 2'b00;
    localparam logic [1:0] VSEW_16 = 2'b01;
    localparam logic [1:0] VSEW_32 = 2'b10;

    function automatic logic [31:0] v_match(input logic [5:0] f6, input logic [2:0] f3);
        return {f6, 11'b0, f3, 5'b0, OPC_OP_V};
    endfunction

    // funct6 + funct3 + major opcode; vm and register fields are don't-care
    localparam logic [31:0] INST_V_MASK        = 32'hFC00707F;
    localparam logic [31:0] INST_VADD_VV_MATCH  = v_match(6'b000000, FUNCT3_OPIVV);
    localparam logic [31:0] INST_VADD_VX_MATCH  = v_match(6'b000000, FUNCT3_OPIVX);
    localparam logic [31:0] INST_VADD_VI_MATCH  = v_match(6'b000000, FUNCT3_OPIVI);
    localparam logic [31:0] INST_VSUB_VV_MATCH  = v_match(6'b000010, FUNCT3_OPIVV);
    localparam logic [31:0] INST_VSUB_VX_MATCH  = v_match(6'b000010, FUNCT3_OPIVX);
    localparam logic [31:0] INST_VRSUB_VX_MATCH = v_match(6'b000011, FUNCT3_OPIVX);
    localparam logic [31:0] INST_VRSUB_VI_MATCH = v_match(6'b000011, FUNCT3_OPIVI);
    localparam logic [31:0] INST_VMINU_VV_MATCH = v_match(6'b000100, FUNCT3_OPIVV);
    localparam logic [31:0] INST_VMINU_VX_MATCH = v_match(6'b000100, FUNCT3_OPIVX);
    localparam logic [31:0] INST_VMIN_VV_MATCH  = v_match(6'b000101, FUNCT3_OPIVV);
    localparam logic [31:0] INST_VMIN_VX_MATCH  = v_match(6'b000101, FUNCT3_OPIVX);
    localparam logic [31:0] INST_VMAXU_VV_MATCH = v_match(6'b000110, FUNCT3_OPIVV);
    localparam logic [31:0] INST_VMAXU_VX_MATCH = v_match(6'b000110, FUNCT3_OPIVX);
    localparam logic [31:0] INST_VMAX_VV_MATCH  = v_match(6'b000111, FUNCT3_OPIVV);
    localparam logic [31:0] INST_VMAX_VX_MATCH  = v_match(6'b000111, FUNCT3_OPIVX);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_RSUB = 3'd2,
        ALU_MINU = 3'd3,
        ALU_MIN  = 3'd4,
        ALU_MAXU = 3'd5,
        ALU_MAX  = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic       alu;     // opcode is one this unit executes
        alu_op_e    op;
        logic [2:0] funct3;  // operand form
        logic       vm;      // 1 = unmasked
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [31:0] inst);
        alu_dec_t   d;
        logic [31:0] k;
        d        = '0;
        k        = inst & INST_V_MASK;
        d.vm     = inst[25];
        d.funct3 = inst[14:12];
        d.alu    = 1'b1;
        if (k == INST_VADD_VV_MATCH || k == INST_VADD_VX_MATCH || k == INST_VADD_VI_MATCH)
            d.op = ALU_ADD;
        else if (k == INST_VSUB_VV_MATCH || k == INST_VSUB_VX_MATCH)
            d.op = ALU_SUB;
        else if (k == INST_VRSUB_VX_MATCH || k == INST_VRSUB_VI_MATCH)
            d.op = ALU_RSUB;
        else if (k == INST_VMINU_VV_MATCH || k == INST_VMINU_VX_MATCH)
            d.op = ALU_MINU;
        else if (k == INST_VMIN_VV_MATCH || k == INST_VMIN_VX_MATCH)
            d.op = ALU_MIN;
        else if (k == INST_VMAXU_VV_MATCH || k == INST_VMAXU_VX_MATCH)
            d.op = ALU_MAXU;
        else if (k == INST_VMAX_VV_MATCH || k == INST_VMAX_VX_MATCH)
            d.op = ALU_MAX;
        else
            d.alu = 1'b0;
        return d;
    endfunction

    // One lane at any width: callers pass zero-extended (u) and sign-extended (s)
    // copies; the caller truncates the result back to SEW.
    function automatic logic [31:0] lane_op(input alu_op_e op,
                                            input logic [31:0] a_u, input logic [31:0] b_u,
                                            input logic [31:0] a_s, input logic [31:0] b_s);
        case (op)
            ALU_ADD:  return a_u + b_u;
            ALU_SUB:  return a_u - b_u;
            ALU_RSUB: return b_u - a_u;
            ALU_MINU: return (a_u < b_u) ? a_u : b_u;
            ALU_MIN:  return ($signed(a_s) < $signed(b_s)) ? a_u : b_u;
            ALU_MAXU: return (a_u > b_u) ? a_u : b_u;
            ALU_MAX:  return ($signed(a_s) > $signed(b_s)) ? a_u : b_u;
            default:  return a_u;
        endcase
    endfunction

endpackage

// File: rtl/biriscv_v_alu_pipe_if.sv
// Issue/writeback bundle between the vector register-file read stage and the ALU.
interface biriscv_v_alu_pipe_if #(
    parameter int VLEN = 128
);
    logic            opcode_valid_i;
    logic [31:0]     opcode_opcode_i;
    logic [4:0]      opcode_vd_idx_i;
    logic [31:0]     opcode_ra_operand_i;
    logic [VLEN-1:0] opcode_va_operand_i;
    logic [VLEN-1:0] opcode_vb_operand_i;
    logic [VLEN-1:0] opcode_vd_operand_i;
    logic [VLEN-1:0] opcode_vmask_operand_i;
    logic [1:0]      vsew_i;
    logic            hold_i;
    logic            writeback_valid_o;
    logic [4:0]      writeback_vd_idx_o;
    logic [VLEN-1:0] writeback_value_o;

    modport master (
        output opcode_valid_i, opcode_opcode_i, opcode_vd_idx_i, opcode_ra_operand_i,
               opcode_va_operand_i, opcode_vb_operand_i, opcode_vd_operand_i,
               opcode_vmask_operand_i, vsew_i, hold_i,
        input  writeback_valid_o, writeback_vd_idx_o, writeback_value_o
    );

    modport slave (
        input  opcode_valid_i, opcode_opcode_i, opcode_vd_idx_i, opcode_ra_operand_i,
               opcode_va_operand_i, opcode_vb_operand_i, opcode_vd_operand_i,
               opcode_vmask_operand_i, vsew_i, hold_i,
        output writeback_valid_o, writeback_vd_idx_o, writeback_value_o
    );
endinterface

// File: rtl/biriscv_v_alu_slice.sv
// One 32-bit slice of the vector ALU: 4x8, 2x16 or 1x32 lanes, combinational,
// with mask-undisturbed merge against the old destination data.
module biriscv_v_alu_slice
    import biriscv_v_alu_pipe_pkg::*;
(
    input  logic [1:0]  sew,
    input  alu_op_e     op,
    input  logic [31:0] vs2,
    input  logic [31:0] op1,
    input  logic [31:0] vd,
    input  logic [3:0]  lane_en,  // active bit per lane, lane 0 in bit 0
    output logic [31:0] result
);
    logic [31:0] r8, r16, r32, res;
    logic [3:0]  byte_en;

    for (genvar i = 0; i < 4; i++) begin : g_b
        assign r8[8*i +: 8] = 8'(lane_op(op, 32'(vs2[8*i +: 8]), 32'(op1[8*i +: 8]),
                                         32'($signed(vs2[8*i +: 8])), 32'($signed(op1[8*i +: 8]))));
    end

    for (genvar j = 0; j < 2; j++) begin : g_h
        assign r16[16*j +: 16] = 16'(lane_op(op, 32'(vs2[16*j +: 16]), 32'(op1[16*j +: 16]),
                                             32'($signed(vs2[16*j +: 16])), 32'($signed(op1[16*j +: 16]))));
    end

    assign r32 = lane_op(op, vs2, op1, vs2, op1);

    // Pick the SEW view and expand lane enables into byte enables
    always_comb begin
        res     = r32;
        byte_en = {4{lane_en[0]}};
        case (sew)
            VSEW_8: begin
                res     = r8;
                byte_en = lane_en;
            end
            VSEW_16: begin
                res     = r16;
                byte_en = {{2{lane_en[1]}}, {2{lane_en[0]}}};
            end
            default: ;
        endcase
    end

    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign result[8*b +: 8] = byte_en[b] ? res[8*b +: 8] : vd[8*b +: 8];
    end

endmodule

// File: rtl/biriscv_v_alu_pipe.sv
// Pipelined RVV integer ALU: decode, scalar replication, VLEN/32 slices, and a
// STAGES-deep register chain freezing on hold.
module biriscv_v_alu_pipe
    import biriscv_v_alu_pipe_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int STAGES = 2
)(
    input  logic clk_i,
    input  logic rst_i,
    biriscv_v_alu_pipe_if.slave io
);
    localparam int SLICES = VLEN / 32;

    alu_dec_t                   dec;
    logic                       accept;
    logic [31:0]                scalar;
    logic [31:0]                op1_rep;
    logic [SLICES-1:0][31:0]    s0_val;

    logic [STAGES:1]            vld_pipe;
    logic [STAGES:1][4:0]       idx_pipe;
    logic [STAGES:1][VLEN-1:0]  val_pipe;

    // Only the low VLEN/8 v0 bits can ever address an element (SEW=8 worst case)
    logic unused_v0;
    assign unused_v0 = ^io.opcode_vmask_operand_i[VLEN-1:VLEN/8];

    assign dec    = alu_decode(io.opcode_opcode_i);
    assign accept = io.opcode_valid_i & dec.alu & ~io.hold_i;

    // Scalar operand (rs1 or sign-extended simm5) replicated across a 32-bit word
    always_comb begin
        scalar  = (dec.funct3 == FUNCT3_OPIVX) ? io.opcode_ra_operand_i
                                               : {{27{io.opcode_opcode_i[19]}}, io.opcode_opcode_i[19:15]};
        op1_rep = scalar;
        case (io.vsew_i)
            VSEW_8:  op1_rep = {4{scalar[7:0]}};
            VSEW_16: op1_rep = {2{scalar[15:0]}};
            default: ;
        endcase
    end

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [3:0]  lane_en;
        logic [31:0] op1;

        assign op1 = (dec.funct3 == FUNCT3_OPIVV) ? io.opcode_va_operand_i[32*s +: 32] : op1_rep;

        // v0 bit i guards element i of the whole register, so the slice's bits move with SEW
        always_comb begin
            lane_en = 4'hF;
            if (!dec.vm) begin
                case (io.vsew_i)
                    VSEW_8:  lane_en = io.opcode_vmask_operand_i[4*s +: 4];
                    VSEW_16: lane_en = {2'b00, io.opcode_vmask_operand_i[2*s +: 2]};
                    default: lane_en = {3'b000, io.opcode_vmask_operand_i[s]};
                endcase
            end
        end

        biriscv_v_alu_slice u_slice (
            .sew     (io.vsew_i),
            .op      (dec.op),
            .vs2     (io.opcode_vb_operand_i[32*s +: 32]),
            .op1     (op1),
            .vd      (io.opcode_vd_operand_i[32*s +: 32]),
            .lane_en (lane_en),
            .result  (s0_val[s])
        );
    end

    // Result chain; reset clears everything, hold freezes every stage including outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
            val_pipe <= '0;
        end else if (!io.hold_i) begin
            vld_pipe[1] <= accept;
            idx_pipe[1] <= io.opcode_vd_idx_i;
            val_pipe[1] <= s0_val;
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
                val_pipe[k] <= val_pipe[k-1];
            end
        end
    end

    assign io.writeback_valid_o  = vld_pipe[STAGES];
    assign io.writeback_vd_idx_o = idx_pipe[STAGES];
    assign io.writeback_value_o  = val_pipe[STAGES];

endmodule

// File: doc/biriscv_v_alu_pipe.md
# biriscv_v_alu_pipe

Parametrised, pipelined RVV integer ALU for the biRISC-V vector issue path. It accepts one vector arithmetic opcode per cycle and computes the result on all elements in parallel, at a selectable element width (SEW 8/16/32). It applies v0 masking with mask-undisturbed policy and returns a full VLEN-bit writeback after a configurable number of register stages. It sits beside the scalar execute units, fed by the vector register-file read stage, and writes back to the vector register file.

## Interface
Parameters:
- VLEN, 128: vector register width in bits; multiple of 32, range 32..1024.
- STAGES, 2: pipeline depth (opcode-to-writeback latency), range 1..3.

Clock and reset:
- One clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.

Ports:
- opcode_valid_i  in  1  opcode present this cycle.
- opcode_opcode_i  in  32  instruction word.
- opcode_vd_idx_i  in  5  destination vector register.
- opcode_ra_operand_i  in  32  scalar rs1 value (.vx forms).
- opcode_va_operand_i  in  VLEN  vs1 data.
- opcode_vb_operand_i  in  VLEN  vs2 data.
- opcode_vd_operand_i  in  VLEN  old vd data (undisturbed elements).
- opcode_vmask_operand_i  in  VLEN  v0 data.
- vsew_i  in  2  element width: 00 = 8, 01 = 16, 10 = 32, 11 = reserved (treated as 32).
- hold_i  in  1  pipeline stall.
- writeback_valid_o  out  1  result valid.
- writeback_vd_idx_o  out  5  destination of the result.
- writeback_value_o  out  VLEN  result vector.

## Operation
- Decode: major opcode 1010111; funct3 selects the scalar operand form: 000 = OPIVV, 100 = OPIVX, 011 = OPIVI.
- funct6 selects the operation:
  - 000000 vadd: vs2 + op1.
  - 000010 vsub: vs2 − op1 (.vv/.vx only).
  - 000011 vrsub: op1 − vs2 (.vx/.vi only).
  - 000100 vminu, 000101 vmin, 000110 vmaxu, 000111 vmax (.vv/.vx only).
- Any other opcode is not an ALU opcode. It is not accepted, and no writeback is produced for it.
- op1 per form:
  - .vv: vs1 element.
  - .vx: rs1[SEW-1:0], replicated into every element.
  - .vi: simm5 = opcode[19:15], sign-extended to SEW.
- Arithmetic is modulo 2^SEW, with no carry between elements.
  - vmin/vmax compare as two's-complement signed.
  - vminu/vmaxu compare unsigned.
- Elements: VLEN/SEW per register. Element i occupies bits [(i+1)·SEW−1 : i·SEW].
- Masking:
  - vm = opcode[25]. When vm = 1, every element is active.
  - When vm = 0, element i is active iff v0 bit i (opcode_vmask_operand_i[i]) is 1.
  - Inactive elements take the opcode_vd_operand_i element unchanged (mask-undisturbed).
- Acceptance: an opcode is accepted when opcode_valid_i = 1, it is an ALU opcode, and hold_i = 0.
- Accepted results carry vd_idx and a valid bit through every stage.

## Timing
- Reset (synchronous): all stage valid bits, writeback_valid_o, writeback_vd_idx_o and writeback_value_o are 0 after the first rising edge with rst_i = 1.
- Reset mid-operation discards every in-flight result; no writeback is produced for any of them.
- Latency:
  - An opcode accepted at edge N presents writeback_valid_o = 1 after edge N+STAGES−1 (STAGES registered stages; the outputs are registers).
  - STAGES = 1 therefore gives the result in the cycle after issue.
- Throughput: one opcode per cycle. Back-to-back opcodes appear on consecutive writeback cycles in issue order.
- hold_i = 1:
  - Every stage, including the outputs, freezes.
  - A valid opcode on the input is not accepted; upstream keeps it asserted until hold_i falls.
  - writeback_valid_o keeps its value. Downstream treats the writeback as consumed only when hold_i = 0.
- rst_i has priority over hold_i.
- Bubble handling: a cycle with no accepted opcode inserts valid = 0. Data registers may keep stale values, but writeback_valid_o = 0 is authoritative.
- Changing vsew_i between opcodes is legal. It is sampled with the opcode at acceptance.

## Structure
- biriscv_defs.v gains:
  - INST_VSUB/VRSUB/VMIN/VMAX/VMINU/VMAXU/VADD per-form MASK/MATCH pairs.
  - The funct3 form constants.
  - The VSEW_8/16/32 encodings.
- Sub-module biriscv_v_alu_slice:
  - One 32-bit slice holding 4×8, 2×16 or 1×32 lanes per SEW.
  - Implements the add/sub/min/max and masking combinationally.
  - Instantiated VLEN/32 times.
  - Takes the four mask bits relevant to its lanes.
- The top level holds the decode, the operand replication, and the STAGES-deep register chain.

## Test plan
- Reset, then vadd.vv at SEW=32, vm=1, vs2 = 4×0x00000005, vs1 = 4×0xFFFFFFFF, STAGES=2 -> writeback_valid_o high exactly 2 cycles after issue; value 4×0x00000004.
- SEW=8, vsub.vx, rs1 = 0x1FF (truncated to 0xFF), vs2 bytes = 0x00 -> every byte 0x01, no cross-byte borrow.
- SEW=16, vrsub.vi with simm5 = 0x10 (−16), vs2 halves = 0x0001 -> every half 0xFFEF.
- vmin.vv vs vminu.vv at SEW=8, vs2 = 0x80, vs1 = 0x01 -> 0x80 signed, 0x01 unsigned.
- vadd.vv vm=0, v0 = 0b0101, SEW=32, old vd = 4×0xDEADBEEF -> elements 0 and 2 hold the sum; elements 1 and 3 hold 0xDEADBEEF.
- Back-to-back issue of 3 opcodes, hold_i asserted for 2 cycles after the second, then rst_i asserted with one result still in flight -> hold: outputs frozen and in-order results. Reset: no writeback for the in-flight result, all outputs 0.
